// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command byte transmitter.
// Define PS2_TX_RETRY_EN to retransmit once after a NAK or timeout.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       ar,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic [1:0] err_code,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    ACK,
    WAIT_REL
  } state_t;

  state_t                state;
  logic [FILTER_LEN-1:0] sreg;
  logic                  filt;
  logic                  filt_q;
  logic                  fall;
  logic [9:0]            shift;
  logic [3:0]            bit_idx;
  logic [IW-1:0]         inh_cnt;
  logic [TW-1:0]         to_cnt;
  logic                  timing;
  logic                  to_hit;
  logic                  nak;
  logic                  fail;
  logic [1:0]            fail_code;
`ifdef PS2_TX_RETRY_EN
  logic                  retried;
`endif

  // Reset to all-ones so leaving reset never looks like a falling edge
  always_ff @(posedge clk) begin
    if (ar) begin
      sreg   <= '1;
      filt   <= 1'b1;
      filt_q <= 1'b1;
    end else begin
      sreg   <= {sreg[FILTER_LEN-2:0], ps2_clk_in};
      if (&sreg)
        filt <= 1'b1;
      else if (~|sreg)
        filt <= 1'b0;
      filt_q <= filt;
    end
  end

  assign fall   = filt_q & ~filt;
  assign timing = (state == SEND) || (state == ACK) ||
                  (state == WAIT_REL);
  assign to_hit = timing && (to_cnt == TO_LAST);
  assign nak    = (state == ACK) && fall && ps2_dat_in;
  assign fail   = to_hit | nak;
  assign fail_code = to_hit ? 2'b10 : 2'b01;

  always_ff @(posedge clk) begin
    if (ar) begin
      state      <= IDLE;
      tx_ready   <= 1'b1;
      tx_done    <= 1'b0;
      tx_err     <= 1'b0;
      err_code   <= 2'b00;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      shift      <= '0;
      bit_idx    <= '0;
      inh_cnt    <= '0;
      to_cnt     <= '0;
`ifdef PS2_TX_RETRY_EN
      retried    <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
      if (timing)
        to_cnt <= to_cnt + TW'(1);
      // Timeout outranks a clock fall landing in the same cycle
      if (fail) begin
`ifdef PS2_TX_RETRY_EN
        if (!retried) begin
          retried    <= 1'b1;
          state      <= INHIBIT;
          inh_cnt    <= '0;
          ps2_clk_oe <= 1'b1;
          ps2_dat_oe <= 1'b0;
        end else begin
`else
        begin
`endif
          state      <= IDLE;
          tx_err     <= 1'b1;
          err_code   <= fail_code;
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
        end
      end else begin
        unique case (state)
          IDLE: begin
`ifdef PS2_TX_RETRY_EN
            retried <= 1'b0;
`endif
            if (tx_ready && tx_valid) begin
              shift      <= {1'b1, ~^tx_data, tx_data};
              inh_cnt    <= '0;
              ps2_clk_oe <= 1'b1;
              tx_ready   <= 1'b0;
              state      <= INHIBIT;
            end else begin
              tx_ready   <= 1'b1;
            end
          end
          INHIBIT: begin
            if (inh_cnt == INH_LAST) begin
              ps2_dat_oe <= 1'b1;
              state      <= REQ;
            end else begin
              inh_cnt <= inh_cnt + IW'(1);
            end
          end
          REQ: begin
            ps2_clk_oe <= 1'b0;
            bit_idx    <= '0;
            to_cnt     <= '0;
            state      <= SEND;
          end
          SEND: begin
            if (fall) begin
              ps2_dat_oe <= ~shift[bit_idx];
              bit_idx    <= bit_idx + 4'd1;
              if (bit_idx == 4'd9)
                state <= ACK;
            end
          end
          ACK: begin
            if (fall)
              state <= WAIT_REL;
          end
          WAIT_REL: begin
            if (filt && ps2_dat_in) begin
              tx_done <= 1'b1;
              state   <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
